// File: rtl/logic_unit_pkg.sv
// Shared types for the multi-cycle bitwise logic unit: opcodes, FSM states and
// a helper that sizes the chunk counter.
package logic_unit_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOT  = 3'b000;
  localparam opcode_t OP_AND  = 3'b001;
  localparam opcode_t OP_OR   = 3'b010;
  localparam opcode_t OP_XOR  = 3'b011;
  localparam opcode_t OP_NAND = 3'b100;
  localparam opcode_t OP_NOR  = 3'b101;
  localparam opcode_t OP_XNOR = 3'b110;
  localparam opcode_t OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk operation still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit slice implementing the eight bitwise operations.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  opcode_t          op_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic [CHUNK-1:0] y_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    y_o = a_i;
    case (op_i)
      OP_NOT:  y_o = ~a_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_PASS: y_o = a_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches operands on accept, computes CHUNK bits
// per cycle LSB first, then presents result and zero flag until consumed.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  opcode_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $fatal(1, "logic_unit_seq: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  opcode_t          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [CHUNK-1:0] a_chunk, b_chunk, y_chunk;

  assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .op_i (op_q),
    .a_i  (a_chunk),
    .b_i  (b_chunk),
    .y_o  (y_chunk)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i)        state_d = BUSY;
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready_i)       state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    result_o    = result_q;
    zero_o      = zero_q;
  end

  assign accept = in_valid_i && (state_q == IDLE);

  // Datapath next-state: unwritten result chunks keep their old contents.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      a_d   = a_i;
      b_d   = b_i;
      op_d  = op_i;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      result_d[cnt_q*CHUNK +: CHUNK] = y_chunk;
      cnt_d = cnt_q + 1'b1;
      // Zero is taken from the full result including the chunk written now.
      if (cnt_q == CNT_LAST) zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOT;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: whole-word reference model checked every cycle on the
// default configuration, plus PASS latency checks on 16/16 and 64/8 instances.
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  logic clk, rst;

  logic        in_valid, in_ready, out_valid, out_ready, zero;
  opcode_t     op;
  logic [31:0] a, b, result;

  logic        v16_in_valid, v16_in_ready, v16_out_valid, v16_out_ready, v16_zero;
  opcode_t     v16_op;
  logic [15:0] v16_a, v16_b, v16_result;

  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_zero;
  opcode_t     v64_op;
  logic [63:0] v64_a, v64_b, v64_result;

  int n_tests = 0;
  int n_fail  = 0;

  logic_unit_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero)
  );

  logic_unit_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v16_in_valid), .in_ready_o(v16_in_ready),
    .op_i(v16_op), .a_i(v16_a), .b_i(v16_b), .out_valid_o(v16_out_valid),
    .out_ready_i(v16_out_ready), .result_o(v16_result), .zero_o(v16_zero)
  );

  logic_unit_seq #(.WIDTH(64), .CHUNK(8)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v64_in_valid), .in_ready_o(v64_in_ready),
    .op_i(v64_op), .a_i(v64_a), .b_i(v64_b), .out_valid_o(v64_out_valid),
    .out_ready_i(v64_out_ready), .result_o(v64_result), .zero_o(v64_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lu(input opcode_t f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      OP_NOT:  return ~x;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NAND: return ~(x & y);
      OP_NOR:  return ~(x | y);
      OP_XNOR: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Reference model: an accepted op produces its whole-word answer 4 edges later.
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_known = 1'b0;
  int          m_left  = 0;
  logic [31:0] m_final = '0;
  logic [31:0] m_res   = '0;
  logic        m_zero  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_known = 1'b1; m_res = '0; m_zero = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_known = 1'b1;
        m_res = m_final; m_zero = (m_final == 32'h0);
      end
    end else if (in_valid) begin
      m_busy = 1'b1; m_left = 4; m_final = lu(op, a, b); m_known = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc in_ready", in_ready, !(m_busy || m_done));
    check("cyc out_valid", out_valid, m_done);
    if (m_known) begin
      check("cyc result", result, m_res);
      check("cyc zero", zero, m_zero);
    end
  end

  // Starts #1 after an edge with the unit idle; returns #1 after the handshake edge.
  task automatic run_op(input string name, input opcode_t f, input logic [31:0] av,
                        input logic [31:0] bv, input int stall,
                        input logic [31:0] exp_r, input logic exp_z);
    int lat;
    op = f; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs and keep in_valid high while busy: all must be ignored.
    a = ~av; b = ~bv; op = ~f; out_ready = (stall == 0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, lat, 4);
    check({name, " result"}, result, exp_r);
    check({name, " zero"}, zero, exp_z);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({name, " stall in_ready"}, in_ready, 1'b0);
      check({name, " stall out_valid"}, out_valid, 1'b1);
      check({name, " stall result"}, result, exp_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check({name, " back to idle"}, in_ready, 1'b1);
  endtask

  task automatic run_pass16(input logic [15:0] av);
    int lat;
    v16_op = OP_PASS; v16_a = av; v16_b = ~av; v16_in_valid = 1'b1; v16_out_ready = 1'b1;
    @(posedge clk); #1;
    v16_in_valid = 1'b0; v16_a = ~av;
    lat = 0;
    while (!v16_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("w16 latency", lat, 1);
    check("w16 result", v16_result, av);
    check("w16 zero", v16_zero, av == 16'h0);
    @(posedge clk); #1;
    check("w16 idle", v16_in_ready, 1'b1);
  endtask

  task automatic run_pass64(input logic [63:0] av);
    int lat;
    v64_op = OP_PASS; v64_a = av; v64_b = ~av; v64_in_valid = 1'b1; v64_out_ready = 1'b1;
    @(posedge clk); #1;
    v64_in_valid = 1'b0; v64_a = ~av;
    lat = 0;
    while (!v64_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("w64 latency", lat, 8);
    check("w64 result", v64_result, av);
    check("w64 zero", v64_zero, av == 64'h0);
    @(posedge clk); #1;
    check("w64 idle", v64_in_ready, 1'b1);
  endtask

  initial begin
    opcode_t     rop;
    logic [31:0] ra, rb;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = OP_NOT; a = '0; b = '0;
    v16_in_valid = 1'b0; v16_out_ready = 1'b0; v16_op = OP_NOT; v16_a = '0; v16_b = '0;
    v64_in_valid = 1'b0; v64_out_ready = 1'b0; v64_op = OP_NOT; v64_a = '0; v64_b = '0;
    #1 rst = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 32'h0);
    check("reset zero", zero, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("not",  OP_NOT,  32'h0F0F_00FF, 32'h1234_5678, 0, 32'hF0F0_FF00, 1'b0);
    run_op("and",  OP_AND,  32'hFFFF_0000, 32'h0000_FFFF, 0, 32'h0000_0000, 1'b1);
    run_op("xnor", OP_XNOR, 32'hFFFF_0000, 32'h0000_FFFF, 0, 32'h0000_0000, 1'b1);
    run_op("xor",  OP_XOR,  32'hFFFF_0000, 32'h0000_FFFF, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("or",   OP_OR,   32'h0000_0001, 32'h0000_0002, 5, 32'h0000_0003, 1'b0);
    run_op("nand", OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1);

    // Reset in the second BUSY cycle discards the operation.
    op = OP_XOR; a = 32'hFFFF_FFFF; b = 32'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1'b1);
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midreset no output", out_valid, 1'b0);

    run_op("nor",  OP_NOR,  32'h0, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op("pass", OP_PASS, 32'hDEAD_BEEF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rop = opcode_t'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      run_op("rand", rop, ra, rb, i % 3, lu(rop, ra, rb), lu(rop, ra, rb) == 32'h0);
    end

    run_pass16(16'hA5C3);
    run_pass16(16'(($urandom)));
    run_pass16(16'h0000);
    run_pass64(64'h0123_4567_89AB_CDEF);
    run_pass64({$urandom, $urandom});
    run_pass64(64'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the ALU. It generalises the fixed 32-bit inverter to eight bitwise operations on WIDTH-bit operands. Operands are processed CHUNK bits per cycle, LSB chunk first, behind a valid/ready handshake on both sides. It sits beside the adder/shifter in the ALU datapath and feeds a result plus zero flag to the writeback mux.

## Interface
- WIDTH, 32, operand/result width in bits
- CHUNK, 8, bits processed per cycle; must divide WIDTH (elaboration-time check, fatal otherwise)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  unit can accept
- op  in  3  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored by NOT, PASS)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, valid while out_valid

## Operation
- Opcodes: 000 NOT A, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS A. All eight are defined; there are no illegal codes.
- States: IDLE, BUSY, DONE. N = WIDTH/CHUNK.
- IDLE: in_ready=1. When in_valid&&in_ready, latch a, b and op, clear cnt to 0, and go to BUSY. Inputs are sampled only at the accept edge; later changes on a/b/op are ignored.
- BUSY: each edge writes result[cnt*CHUNK +: CHUNK] = f(op, a_chunk, b_chunk) and increments cnt. On the edge where cnt==N-1, go to DONE. in_ready=0.
- DONE: out_valid=1, with result and zero stable. When out_valid&&out_ready, go to IDLE. A new input is not accepted in the same cycle; in_ready stays 0 until IDLE.
- zero: registered on the BUSY→DONE edge from the final full result (last chunk included).
- Result bits not yet written during BUSY hold their previous contents. result is only valid while out_valid is high.
- cnt is ceil(log2(N)) bits, minimum 1. When N==1, BUSY lasts exactly one cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, zero=0, cnt=0.
- Latency: out_valid rises N edges after the accept edge (4 for the defaults).
- Throughput: one operation per N+2 cycles when out_ready is held high (accept, N BUSY edges, DONE handshake edge).
- Back-pressure: DONE holds indefinitely while out_ready=0, with result, zero and out_valid unchanged.
- Reset mid-operation (BUSY or DONE): immediate asynchronous return to IDLE with all reset values. The in-flight operation is discarded and no out_valid is produced.
- out_ready asserted outside DONE has no effect. in_valid asserted outside IDLE is ignored and not queued.

## Structure
- Package logic_unit_pkg holds the opcode localparams (OP_NOT … OP_PASS), the 3-bit opcode typedef, and the state enum (IDLE/BUSY/DONE).
- Sub-module logic_slice: combinational, parameter CHUNK, ports op, a, b, y; implements the eight-op mux. The top instantiates one slice; the FSM, counter, operand registers and result register live in logic_unit_seq.

## Test plan
- Reset, then NOT with a=32'h0F0F_00FF and out_ready=1 → out_valid on the 4th edge after accept; result=32'hF0F0_FF00, zero=0.
- AND with a=32'hFFFF_0000, b=32'h0000_FFFF → result=0, zero=1; XNOR with the same operands → result=32'h0000_0000, zero=1; XOR → 32'hFFFF_FFFF, zero=0.
- Back-pressure: OR with a=32'h1, b=32'h2 and out_ready=0 for 5 cycles → out_valid and result=32'h3 held stable and in_ready=0 throughout; release out_ready → IDLE next cycle.
- Operand change after accept: NAND with a=b=32'hFFFF_FFFF, then drive a=0 during BUSY → result=0, zero=1 (the latched operands are used).
- Reset asserted on the 2nd BUSY cycle → out_valid never rises, result=0, in_ready=1 immediately; the next NOR with a=b=0 → 32'hFFFF_FFFF.
- Parameter sweep: WIDTH=16/CHUNK=16 gives latency 1; WIDTH=64/CHUNK=8 gives latency 8. PASS of random a equals a in every case; WIDTH=32/CHUNK=5 fails elaboration.
